// File: rtl/pry_rr_arb.sv
// pry_rr_arb: round-robin arbiter sharing one downstream resource between
// WIDTH requesters. The grant is registered, one-hot, and held until the
// resource accepts it (vld && rdy). Asserting lck on an accepted transfer keeps
// the same requester granted for a back-to-back burst.
//
// Ports:
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low reset
//   req    - level request per requester
//   lck    - keep the current grant across the handshake
//   gnt    - registered one-hot grant, zero when idle
//   idx    - binary index of the granted requester, zero when idle
//   vld    - grant valid (|gnt)
//   rdy    - resource ready; transfer completes on vld && rdy
//
// pry2thr: priority-to-thermometer converter. In "LSB" mode thr[i] is set when
// any bit at or below i is set; "MSB" mode is the mirror image. The search is
// done in blocks of SPLIT bits. Inside a block IMPLEMENTATION picks a loop (0),
// a log-step shift/OR (1) or an adder (2); a carry from lower blocks fills the
// rest.
//
// Ports:
//   pry - input vector
//   thr - thermometer output

module pry2thr #(
  parameter int unsigned WIDTH          = 9,
  parameter int unsigned SPLIT          = 3,
  parameter              DIRECTION      = "LSB",
  parameter int unsigned IMPLEMENTATION = 0
) (
  input  logic [WIDTH-1:0] pry,
  output logic [WIDTH-1:0] thr
);

  localparam bit          MSB = (DIRECTION == "MSB");
  localparam int unsigned NB  = (WIDTH + SPLIT - 1) / SPLIT;
  localparam int unsigned PW  = NB * SPLIT;

  logic [WIDTH-1:0] p_l;
  logic [WIDTH-1:0] t_l;
  logic [PW-1:0]    pp;
  logic [PW-1:0]    tt;

  // Thermometer of one SPLIT-wide block, lowest set bit upward.
  function automatic logic [SPLIT-1:0] thr_blk(input logic [SPLIT-1:0] v);
    logic [SPLIT-1:0] t;
    logic             acc;
    t   = '0;
    acc = 1'b0;
    if (IMPLEMENTATION == 1) begin
      t = v;
      for (int unsigned s = 1; s < SPLIT; s = s * 2) t = t | (t << s);
    end else if (IMPLEMENTATION == 2) begin
      // v | -v sets every bit from the lowest set bit upward.
      t = v | (~v + SPLIT'(1));
    end else begin
      for (int unsigned i = 0; i < SPLIT; i++) begin
        acc  = acc | v[i];
        t[i] = acc;
      end
    end
    return t;
  endfunction

  // "MSB" mode reuses the LSB search on a bit-reversed vector.
  always_comb begin
    p_l = '0;
    for (int unsigned i = 0; i < WIDTH; i++) p_l[i] = MSB ? pry[WIDTH-1-i] : pry[i];
  end

  always_comb begin
    logic             carry;
    logic [SPLIT-1:0] blk;
    pp = '0;
    pp[WIDTH-1:0] = p_l;
    tt    = '0;
    carry = 1'b0;
    for (int unsigned b = 0; b < NB; b++) begin
      blk = pp[b*SPLIT +: SPLIT];
      tt[b*SPLIT +: SPLIT] = thr_blk(blk) | {SPLIT{carry}};
      carry = carry | (|blk);
    end
  end

  assign t_l = tt[WIDTH-1:0];

  always_comb begin
    thr = '0;
    for (int unsigned i = 0; i < WIDTH; i++) thr[i] = MSB ? t_l[WIDTH-1-i] : t_l[i];
  end

endmodule

module pry_rr_arb #(
  parameter int unsigned WIDTH          = 9,
  parameter int unsigned SPLIT          = 3,
  parameter              DIRECTION      = "LSB",
  parameter int unsigned IMPLEMENTATION = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         req,
  input  logic                     lck,
  output logic [WIDTH-1:0]         gnt,
  output logic [$clog2(WIDTH)-1:0] idx,
  output logic                     vld,
  input  logic                     rdy
);

  localparam int unsigned IW  = $clog2(WIDTH);
  localparam bit          MSB = (DIRECTION == "MSB");

  typedef enum logic {
    IDLE,
    GNT
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] gnt_q;
  logic [IW-1:0]    idx_q;
  logic             vld_q;
  logic [WIDTH-1:0] msk_q;

  logic [WIDTH-1:0] gthr;
  logic [WIDTH-1:0] msk_d;
  logic             done;
  logic [WIDTH-1:0] msk_use;
  logic [WIDTH-1:0] mreq;
  logic [WIDTH-1:0] src;
  logic [WIDTH-1:0] athr;
  logic [WIDTH-1:0] arb_gnt_d;
  logic [IW-1:0]    arb_idx_d;

  pry2thr #(
    .WIDTH          (WIDTH),
    .SPLIT          (SPLIT),
    .DIRECTION      (DIRECTION),
    .IMPLEMENTATION (IMPLEMENTATION)
  ) u_thr_gnt (
    .pry (gnt_q),
    .thr (gthr)
  );

  // Thermometer minus the granted bit leaves exactly the positions past the
  // served one in search order, for either direction.
  assign msk_d = gthr & ~gnt_q;

  // On a completing unlocked transfer the next grant must already see the
  // updated mask, so bypass the register in that cycle.
  assign done    = (state_q == GNT) && rdy && !lck;
  assign msk_use = done ? msk_d : msk_q;
  assign mreq    = req & msk_use;
  assign src     = (|mreq) ? mreq : req;

  pry2thr #(
    .WIDTH          (WIDTH),
    .SPLIT          (SPLIT),
    .DIRECTION      (DIRECTION),
    .IMPLEMENTATION (IMPLEMENTATION)
  ) u_thr_arb (
    .pry (src),
    .thr (athr)
  );

  assign arb_gnt_d = MSB ? (athr & ~(athr >> 1)) : (athr & ~(athr << 1));

  always_comb begin
    arb_idx_d = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (arb_gnt_d[i]) arb_idx_d = arb_idx_d | IW'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      vld_q   <= 1'b0;
      msk_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req) begin
            gnt_q   <= arb_gnt_d;
            idx_q   <= arb_idx_d;
            vld_q   <= 1'b1;
            state_q <= GNT;
          end
        end
        GNT: begin
          if (done) begin
            msk_q <= msk_d;
            if (|req) begin
              gnt_q <= arb_gnt_d;
              idx_q <= arb_idx_d;
            end else begin
              gnt_q   <= '0;
              idx_q   <= '0;
              vld_q   <= 1'b0;
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= '0;
          idx_q   <= '0;
          vld_q   <= 1'b0;
        end
      endcase
    end
  end

  assign gnt = gnt_q;
  assign idx = idx_q;
  assign vld = vld_q;

endmodule

// File: tb/tb_pry_rr_arb.sv
// Testbench for pry_rr_arb: six instances (LSB/MSB x three implementations)
// share one stimulus stream and are compared each cycle against a circular
// search reference model.

module tb_pry_rr_arb;

  localparam int W  = 9;
  localparam int IW = 4;
  localparam int ND = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  req = '0;
  logic          lck = 1'b0;
  logic          rdy = 1'b0;
  logic [W-1:0]  gnt_a [ND];
  logic [IW-1:0] idx_a [ND];
  logic          vld_a [ND];

  int errors = 0;
  int checks = 0;

  // Reference state: granted index (-1 idle) and last served index.
  int mg    [ND];
  int mlast [ND];

  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < ND; gi++) begin : g_dut
      pry_rr_arb #(
        .WIDTH          (W),
        .SPLIT          (3),
        .DIRECTION      (gi >= 3 ? "MSB" : "LSB"),
        .IMPLEMENTATION (gi % 3)
      ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .lck   (lck),
        .gnt   (gnt_a[gi]),
        .idx   (idx_a[gi]),
        .vld   (vld_a[gi]),
        .rdy   (rdy)
      );
    end
  endgenerate

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic bit is_msb(input int d);
    return d >= 3;
  endfunction

  // Circular search starting just past the last served position.
  function automatic int pick(input bit msb, input int last, input logic [W-1:0] r);
    if (r == '0) return -1;
    for (int n = 1; n <= W; n++) begin
      int j;
      j = msb ? last - n : last + n;
      j = ((j % W) + W) % W;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < ND; d++) begin
      mg[d]    = -1;
      mlast[d] = is_msb(d) ? W : -1;
    end
  endtask

  task automatic model_step();
    for (int d = 0; d < ND; d++) begin
      if (mg[d] < 0) begin
        mg[d] = pick(is_msb(d), mlast[d], req);
      end else if (rdy && !lck) begin
        mlast[d] = mg[d];
        mg[d]    = pick(is_msb(d), mlast[d], req);
      end
    end
  endtask

  task automatic check_all(input string tag);
    for (int d = 0; d < ND; d++) begin
      logic [W-1:0] eg;
      eg = '0;
      if (mg[d] >= 0) eg[mg[d]] = 1'b1;
      chk($sformatf("%s gnt dut%0d", tag, d), 32'(gnt_a[d]), 32'(eg));
      chk($sformatf("%s idx dut%0d", tag, d), 32'(idx_a[d]), (mg[d] < 0) ? 32'd0 : 32'(mg[d]));
      chk($sformatf("%s vld dut%0d", tag, d), 32'(vld_a[d]), 32'(mg[d] >= 0));
    end
  endtask

  task automatic cycle(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] hold;
    model_reset();

    // Idle after reset, including lck high while idle.
    do_reset();
    req = '0; rdy = 1'b1; lck = 1'b0;
    for (int i = 0; i < 5; i++) cycle("idle");
    lck = 1'b1;
    for (int i = 0; i < 2; i++) cycle("idle_lck");
    lck = 1'b0;

    // Single request regranted every cycle.
    req = 9'b000010000;
    for (int i = 0; i < 4; i++) begin
      cycle("single");
      for (int d = 0; d < ND; d++) chk($sformatf("single idx4 dut%0d", d), 32'(idx_a[d]), 32'd4);
    end

    // Full rotation from a fresh reset.
    do_reset();
    req = '1; rdy = 1'b1; lck = 1'b0;
    for (int n = 0; n < 11; n++) begin
      cycle("rot");
      for (int d = 0; d < ND; d++)
        chk($sformatf("rot seq dut%0d n%0d", d, n), 32'(idx_a[d]),
            is_msb(d) ? 32'(8 - n % 9) : 32'(n % 9));
    end

    // Wrap and skip after the top index is served.
    req = 9'b100000100;
    cycle("wrap");
    chk("wrap lsb idx2", 32'(idx_a[0]), 32'd2);
    cycle("wrap");
    chk("wrap lsb idx8", 32'(idx_a[0]), 32'd8);

    // Backpressure, then lock, then release.
    do_reset();
    req = 9'b000000101; rdy = 1'b0; lck = 1'b0;
    for (int i = 0; i < 3; i++) cycle("bp");
    chk("bp lsb gnt", 32'(gnt_a[0]), 32'h001);
    rdy = 1'b1; lck = 1'b1;
    for (int i = 0; i < 2; i++) cycle("lock");
    chk("lock lsb gnt", 32'(gnt_a[1]), 32'h001);
    lck = 1'b0;
    cycle("unlock");
    chk("unlock lsb gnt", 32'(gnt_a[2]), 32'h004);
    chk("unlock msb gnt", 32'(gnt_a[3]), 32'h001);

    // Request withdrawn without a handshake: grant held.
    rdy = 1'b0; req = '0;
    for (int i = 0; i < 3; i++) cycle("hold_noreq");
    rdy = 1'b1;
    cycle("drain");

    // Asynchronous reset between edges.
    do_reset();
    req = 9'b000001000; rdy = 1'b0;
    cycle("areset_pre");
    cycle("areset_pre");
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("areset");
    @(negedge clk);
    rst_n = 1'b1;
    req = '1; rdy = 1'b1;
    cycle("areset_post");
    chk("areset_post lsb idx0", 32'(idx_a[0]), 32'd0);
    chk("areset_post msb idx8", 32'(idx_a[4]), 32'd8);

    // Randomized traffic keeping granted requests high until accepted.
    for (int i = 0; i < 2000; i++) begin
      hold = '0;
      for (int d = 0; d < ND; d++) if (mg[d] >= 0) hold[mg[d]] = 1'b1;
      if ($urandom_range(0, 3) == 0) req = hold;
      else req = W'($urandom & $urandom) | hold;
      rdy = ($urandom_range(0, 9) < 7);
      lck = ($urandom_range(0, 4) == 0);
      cycle("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
